// File: rtl/roic_scan_sequencer.sv
// roic_scan_sequencer: parametrised row/column raster scan for the ROIC
// readout path. Each row begins with a one-cycle row-settle slot. Every
// column is then held for H cycles (integration), followed by an optional
// D-cycle gap. All outputs are registered from the next-state values, so
// they change on exactly the edge that moves the FSM.
module roic_scan_sequencer #(
  parameter int N_ROWS = 512,
  parameter int N_COLS = 640,
  parameter int ROW_W  = 9,
  parameter int COL_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [CNT_W-1:0] hold_cycles,
  input  logic [CNT_W-1:0] delay_cycles,
  output logic [ROW_W-1:0] row_addr,
  output logic [COL_W-1:0] col_addr,
  output logic             row_en,
  output logic             col_en,
  output logic             sample,
  output logic             line_done,
  output logic             frame_done,
  output logic             busy,
  output logic [15:0]      frame_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROW_SETUP,
    S_HOLD,
    S_DELAY
  } state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  // Latched H-1 (last hold-cycle index) and latched D for the running frame.
  logic [CNT_W-1:0] r_hold_last, w_hold_last_nxt;
  logic [CNT_W-1:0] r_delay, w_delay_nxt;
  logic [15:0]      r_frame_count, w_frame_count_nxt;
  logic [CNT_W-1:0] w_hold_last_cfg;
  logic             w_line_done_nxt;
  logic             w_frame_done_nxt;
  logic             w_advance;

  logic r_row_en;
  logic r_col_en;
  logic r_sample;
  logic r_line_done;
  logic r_frame_done;
  logic r_busy;

  // H-1 taken from the live input; hold_cycles = 0 is treated as a one-cycle hold.
  assign w_hold_last_cfg = (hold_cycles == '0) ? '0 : (hold_cycles - CNT_ONE);

  // Next-state logic: scan counters, config latch and the one-cycle markers.
  always_comb begin
    // NOTE: every signal written here gets a default first. Without it, a path
    // that leaves a signal unassigned would infer a latch.
    w_state_nxt       = r_state;
    w_row_nxt         = r_row;
    w_col_nxt         = r_col;
    w_cnt_nxt         = r_cnt;
    w_hold_last_nxt   = r_hold_last;
    w_delay_nxt       = r_delay;
    w_frame_count_nxt = r_frame_count;
    w_line_done_nxt   = 1'b0;
    w_frame_done_nxt  = 1'b0;
    w_advance         = 1'b0;

    if ((r_state != S_IDLE) && stop) begin
      // Abort: the frame is dropped with no markers and no count increment.
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            w_state_nxt     = S_ROW_SETUP;
            w_row_nxt       = '0;
            w_col_nxt       = '0;
            w_cnt_nxt       = '0;
            w_hold_last_nxt = w_hold_last_cfg;
            w_delay_nxt     = delay_cycles;
          end
        end
        S_ROW_SETUP: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
        S_HOLD: begin
          if (r_cnt == r_hold_last) begin
            w_cnt_nxt = '0;
            if (r_delay != '0) begin
              w_state_nxt = S_DELAY;
            end else begin
              w_advance = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        S_DELAY: begin
          if (r_cnt == (r_delay - CNT_ONE)) begin
            w_cnt_nxt = '0;
            w_advance = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      // Pixel finished: step column, then row, then close the frame.
      if (w_advance) begin
        if (r_col != COL_LAST) begin
          w_col_nxt   = r_col + COL_W'(1);
          w_state_nxt = S_HOLD;
        end else begin
          w_line_done_nxt = 1'b1;
          w_col_nxt       = '0;
          if (r_row != ROW_LAST) begin
            w_row_nxt   = r_row + ROW_W'(1);
            w_state_nxt = S_ROW_SETUP;
          end else begin
            w_frame_done_nxt  = 1'b1;
            w_frame_count_nxt = r_frame_count + 16'd1;
            w_row_nxt         = '0;
            if (continuous) begin
              w_state_nxt     = S_ROW_SETUP;
              w_hold_last_nxt = w_hold_last_cfg;
              w_delay_nxt     = delay_cycles;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
    end
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_cnt         <= '0;
      r_hold_last   <= '0;
      r_delay       <= '0;
      r_frame_count <= '0;
      r_row_en      <= 1'b0;
      r_col_en      <= 1'b0;
      r_sample      <= 1'b0;
      r_line_done   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge
      // values, so the result does not depend on statement order.
      r_state       <= w_state_nxt;
      r_row         <= w_row_nxt;
      r_col         <= w_col_nxt;
      r_cnt         <= w_cnt_nxt;
      r_hold_last   <= w_hold_last_nxt;
      r_delay       <= w_delay_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_row_en      <= (w_state_nxt != S_IDLE);
      r_col_en      <= (w_state_nxt == S_HOLD);
      r_sample      <= (w_state_nxt == S_HOLD) && (w_cnt_nxt == w_hold_last_nxt);
      r_line_done   <= w_line_done_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
    end
  end

  assign row_addr    = r_row;
  assign col_addr    = r_col;
  assign row_en      = r_row_en;
  assign col_en      = r_col_en;
  assign sample      = r_sample;
  assign line_done   = r_line_done;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_roic_scan_sequencer.sv
// Testbench for roic_scan_sequencer on a 3x4 array. Each launched frame is
// expanded into its list of sample / line / frame events, with cycle numbers
// computed by arithmetic from H and D. A negedge monitor pops and compares
// the events whenever the DUT raises a strobe.
module tb_roic_scan_sequencer;

  localparam int NR = 3;
  localparam int NC = 4;
  localparam int EV_SAMPLE = 0;
  localparam int EV_LINE   = 1;
  localparam int EV_FRAME  = 2;

  typedef struct {
    int          kind;
    int          cyc;
    int          row;
    int          col;
    logic [15:0] fc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [7:0]  hold_cycles = 8'd0;
  logic [7:0]  delay_cycles = 8'd0;
  logic [1:0]  row_addr;
  logic [2:0]  col_addr;
  logic        row_en;
  logic        col_en;
  logic        sample;
  logic        line_done;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          edge_cnt = 0;
  int          busy_cyc = 0;
  int          colen_cyc = 0;
  int          cur_k = 0;
  int          base_busy = 0;
  int          base_colen = 0;
  ev_t         sb[$];
  logic [15:0] exp_fc = 16'd0;

  roic_scan_sequencer #(
    .N_ROWS(NR), .N_COLS(NC), .ROW_W(2), .COL_W(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .hold_cycles(hold_cycles), .delay_cycles(delay_cycles),
    .row_addr(row_addr), .col_addr(col_addr), .row_en(row_en), .col_en(col_en),
    .sample(sample), .line_done(line_done), .frame_done(frame_done),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_h(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int frame_len(input int h, input int d);
    return NR * (1 + NC * (eff_h(h) + d));
  endfunction

  task automatic push_ev(input int kind, input int cyc, input int row, input int col,
                         input logic [15:0] fc);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.row = row; e.col = col; e.fc = fc;
    sb.push_back(e);
  endtask

  // One frame whose ROW_SETUP for row 0 is visible in cycle k.
  task automatic push_frame(input int k, input int h, input int d);
    int hh;
    int rl;
    hh = eff_h(h);
    rl = 1 + NC * (hh + d);
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++)
        push_ev(EV_SAMPLE, k + r * rl + 1 + c * (hh + d) + hh - 1, r, c, 16'd0);
      push_ev(EV_LINE, k + (r + 1) * rl, r, 0, 16'd0);
    end
    exp_fc = exp_fc + 16'd1;
    push_ev(EV_FRAME, k + NR * rl, 0, 0, exp_fc);
  endtask

  // Drop expectations later than cycle t (aborted frame).
  task automatic flush_after(input int t);
    while (sb.size() > 0 && sb[$].cyc > t) begin
      if (sb[$].kind == EV_FRAME) exp_fc = exp_fc - 16'd1;
      void'(sb.pop_back());
    end
  endtask

  // ---------------- monitor ----------------
  task automatic expect_event(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL spurious_event: got kind %0d expected none (cycle %0d)", kind, edge_cnt);
      return;
    end
    e = sb.pop_front();
    check("event_kind", kind, e.kind);
    check("event_cycle", edge_cnt, e.cyc);
    if (kind == EV_SAMPLE) begin
      check("sample_row_addr", row_addr, e.row);
      check("sample_col_addr", col_addr, e.col);
      check("sample_col_en", col_en, 1);
    end
    if (kind == EV_FRAME) check("frame_count_at_done", frame_count, e.fc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sample)     expect_event(EV_SAMPLE);
      if (line_done)  expect_event(EV_LINE);
      if (frame_done) expect_event(EV_FRAME);
      if (busy)   busy_cyc++;
      if (col_en) colen_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_cycle(input int t);
    while (edge_cnt < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic launch(input int n, input int h, input int d);
    hold_cycles  = 8'(h);
    delay_cycles = 8'(d);
    continuous   = (n > 1);
    start        = 1'b1;
    cur_k        = edge_cnt + 1;
    base_busy    = busy_cyc;
    base_colen   = colen_cyc;
    for (int f = 0; f < n; f++) push_frame(cur_k + f * frame_len(h, d), h, d);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int h, input int d);
    int fl;
    fl = frame_len(h, d);
    to_cycle(cur_k + (n - 1) * fl);
    continuous = 1'b0;
    to_cycle(cur_k + n * fl + 1);
    check("busy_after_frame", busy, 0);
    check("frame_done_width", frame_done, 0);
    check("busy_cycle_count", busy_cyc - base_busy, n * fl);
    check("col_en_cycle_count", colen_cyc - base_colen, n * NR * NC * eff_h(h));
    check("frame_count_idle", frame_count, exp_fc);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic abort_at(input int t);
    to_cycle(t);
    stop = 1'b1;
    flush_after(t);
    @(posedge clk);
    #2;
    stop = 1'b0;
    continuous = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_row_en", row_en, 0);
    check("stop_col_en", col_en, 0);
    check("stop_row_addr", row_addr, 0);
    check("stop_col_addr", col_addr, 0);
    check("stop_frame_count", frame_count, exp_fc);
  endtask

  initial begin
    int n;
    int h;
    int d;
    int t;

    // Reset state, before any clock edge.
    #3;
    check("rst_busy", busy, 0);
    check("rst_row_en", row_en, 0);
    check("rst_col_en", col_en, 0);
    check("rst_row_addr", row_addr, 0);
    check("rst_col_addr", col_addr, 0);
    check("rst_sample", sample, 0);
    check("rst_line_done", line_done, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    #9;
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Single shot, H=2 D=1: 39 busy cycles.
    launch(1, 2, 1);
    wait_done(1, 2, 1);

    // hold=0 treated as 1, no gap: 15-cycle frame.
    launch(1, 0, 0);
    wait_done(1, 0, 0);

    // Two back-to-back continuous frames.
    launch(2, 2, 1);
    wait_done(2, 2, 1);

    // Stop during the row 1, column 2 hold, then restart from row 0, column 0.
    launch(1, 2, 1);
    abort_at(cur_k + 13 + 1 + 2 * 3 + int'($urandom_range(0, 1)));
    to_cycle(edge_cnt + 3);
    check("scoreboard_after_stop", sb.size(), 0);
    launch(1, 2, 1);
    wait_done(1, 2, 1);

    // hold_cycles changed mid-frame: the current frame keeps H=2.
    launch(1, 2, 1);
    to_cycle(cur_k + 5);
    hold_cycles = 8'd5;
    wait_done(1, 2, 1);
    launch(1, 5, 1);
    wait_done(1, 5, 1);

    // Randomised configurations, with occasional aborts.
    for (int i = 0; i < 10; i++) begin
      h = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 2));
      launch(n, h, d);
      if ($urandom_range(0, 3) == 0) begin
        t = cur_k + int'($urandom_range(0, n * frame_len(h, d) - 1));
        abort_at(t);
        to_cycle(edge_cnt + 2);
      end else begin
        wait_done(n, h, d);
      end
    end

    // Asynchronous reset during a DELAY cycle.
    launch(1, 2, 2);
    to_cycle(cur_k + 3);
    check("pre_reset_row_en", row_en, 1);
    check("pre_reset_col_en", col_en, 0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_row_en", row_en, 0);
    check("arst_col_en", col_en, 0);
    check("arst_row_addr", row_addr, 0);
    check("arst_col_addr", col_addr, 0);
    check("arst_sample", sample, 0);
    check("arst_frame_count", frame_count, 0);
    sb.delete();
    exp_fc = 16'd0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    launch(1, 1, 0);
    wait_done(1, 1, 0);

    check("final_scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
